// File: rtl/fighter_ctrl_if.sv
// fighter_ctrl_if: per-frame control inputs and registered fighter status outputs
//   master drives frame_tick, btn {block, attack, right, left} and hit
//   slave drives state, position, sprite and attack_active
interface fighter_ctrl_if #(
    parameter int POSITION_DEPTH     = 10,
    parameter int SPRITE_INDEX_DEPTH = 5
);
    logic                          frame_tick;
    logic [3:0]                    btn;
    logic                          hit;
    logic [2:0]                    state;
    logic [POSITION_DEPTH-1:0]     position;
    logic [SPRITE_INDEX_DEPTH-1:0] sprite;
    logic                          attack_active;
    modport master (output frame_tick, btn, hit, input state, position, sprite, attack_active);
    modport slave (input frame_tick, btn, hit, output state, position, sprite, attack_active);
endinterface

// File: rtl/fighter_ctrl.sv
// fighter_ctrl: per-frame fighter state machine with walking, attacking, blocking and hitstun
//   sys_clk : clock
//   rst     : asynchronous active-low reset
//   bus     : slave side of fighter_ctrl_if (frame_tick, btn, hit in; state, position, sprite, attack_active out)
module fighter_ctrl #(
    parameter int POSITION_DEPTH     = 10,
    parameter int SPRITE_INDEX_DEPTH = 5,
    parameter int POS_MIN            = 0,
    parameter int POS_MAX            = 576,
    parameter int START_POS          = 64,
    parameter int WALK_SPEED         = 4,
    parameter int ATTACK_FRAMES      = 12,
    parameter int ACTIVE_START       = 4,
    parameter int ACTIVE_END         = 7,
    parameter int HITSTUN_FRAMES     = 16,
    parameter int ANIM_DIV           = 4
) (
    input logic           sys_clk,
    input logic           rst,
    fighter_ctrl_if.slave bus
);
    localparam int PW = POSITION_DEPTH + 1;
    typedef enum logic [2:0] {IDLE = 3'd0, WALK_L, WALK_R, ATTACK, BLOCK, HITSTUN} state_t;
    state_t                        state_q, ns;
    logic [POSITION_DEPTH-1:0]     pos_q, pos_n;
    logic [PW-1:0]                 pos_x, pos_l, pos_r;
    logic [7:0]                    cnt_q, cnt_n, div_q, div_n;
    logic [1:0]                    ph_q, ph_n;
    logic                          pend_q, pend, entered, changed, div_wrap, act_q;
    logic [SPRITE_INDEX_DEPTH-1:0] spr_q;
    always_comb begin
        pend = pend_q | bus.hit;
        ns = state_q > HITSTUN               ? IDLE :
             pend && state_q == BLOCK        ? BLOCK :
             pend                            ? HITSTUN :
             state_q == ATTACK               ? (cnt_q == 8'(ATTACK_FRAMES - 1) ? IDLE : ATTACK) :
             state_q == HITSTUN              ? (cnt_q == 8'(HITSTUN_FRAMES - 1) ? IDLE : HITSTUN) :
             bus.btn[3]                      ? BLOCK :
             bus.btn[2]                      ? ATTACK :
             bus.btn[1:0] == 2'b01           ? WALK_L :
             bus.btn[1:0] == 2'b10           ? WALK_R : IDLE;
        changed = ns != state_q;
        // a hit taken while already in hitstun is a fresh entry for the frame counter
        entered = changed || (pend && ns == HITSTUN);
        cnt_n = entered ? 8'd0 : cnt_q + {7'd0, cnt_q != 8'hFF};
        div_wrap = div_q == 8'(ANIM_DIV - 1);
        div_n = changed || div_wrap ? 8'd0 : div_q + 8'd1;
        ph_n = changed ? 2'd0 : ph_q + {1'b0, div_wrap};
        // widened by one bit so a step past either bound is caught before it can wrap
        pos_x = {1'b0, pos_q};
        pos_l = pos_x - PW'(WALK_SPEED);
        pos_r = pos_x + PW'(WALK_SPEED);
        pos_n = ns == WALK_L ? (pos_x < PW'(POS_MIN) + PW'(WALK_SPEED) ? POSITION_DEPTH'(POS_MIN) : pos_l[POSITION_DEPTH-1:0]) :
                ns == WALK_R ? (pos_r > PW'(POS_MAX) ? POSITION_DEPTH'(POS_MAX) : pos_r[POSITION_DEPTH-1:0]) : pos_q;
    end
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pos_q   <= POSITION_DEPTH'(START_POS);
            cnt_q   <= 8'd0;
            div_q   <= 8'd0;
            ph_q    <= 2'd0;
            pend_q  <= 1'b0;
            spr_q   <= '0;
            act_q   <= 1'b0;
        end else if (bus.frame_tick) begin
            state_q <= ns;
            pos_q   <= pos_n;
            cnt_q   <= cnt_n;
            div_q   <= div_n;
            ph_q    <= ph_n;
            pend_q  <= 1'b0;
            spr_q   <= SPRITE_INDEX_DEPTH'({ns, ph_n});
            act_q   <= ns == ATTACK && cnt_n >= 8'(ACTIVE_START) && cnt_n <= 8'(ACTIVE_END);
        end else begin
            pend_q  <= pend;
        end
    end
    assign bus.state         = state_q;
    assign bus.position      = pos_q;
    assign bus.sprite        = spr_q;
    assign bus.attack_active = act_q;
endmodule

// File: tb/tb_fighter_ctrl.sv
// tb_fighter_ctrl: scoreboard bench for fighter_ctrl with default parameters
module tb_fighter_ctrl;
    localparam int PD = 10;
    localparam int SD = 5;
    localparam int AF = 12;
    localparam int HF = 16;
    logic sys_clk = 1'b0;
    logic rst = 1'b0;
    always #5 sys_clk = ~sys_clk;
    fighter_ctrl_if #(.POSITION_DEPTH(PD), .SPRITE_INDEX_DEPTH(SD)) bus();
    fighter_ctrl dut (.sys_clk(sys_clk), .rst(rst), .bus(bus));
    typedef struct packed {
        logic [2:0]    st;
        logic [PD-1:0] pos;
        logic [SD-1:0] spr;
        logic          act;
    } exp_t;
    exp_t sb[$];
    int total = 0;
    int bad = 0;
    int m_state, m_pos, m_cnt, m_dwell;
    bit m_pend;
    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic model_step(input logic [3:0] b, input bit h, output exp_t e);
        int ns;
        bit pend;
        pend = m_pend | h;
        m_pend = 1'b0;
        if (m_state > 5) ns = 0;
        else if (pend) ns = (m_state == 4) ? 4 : 5;
        else if (m_state == 3) ns = (m_cnt == AF - 1) ? 0 : 3;
        else if (m_state == 5) ns = (m_cnt == HF - 1) ? 0 : 5;
        else if (b[3]) ns = 4;
        else if (b[2]) ns = 3;
        else if (b[1:0] == 2'b01) ns = 1;
        else if (b[1:0] == 2'b10) ns = 2;
        else ns = 0;
        if (ns == 1) m_pos = (m_pos - 4 < 0) ? 0 : m_pos - 4;
        if (ns == 2) m_pos = (m_pos + 4 > 576) ? 576 : m_pos + 4;
        m_cnt = (ns != m_state || (pend && ns == 5)) ? 0 : (m_cnt == 255 ? 255 : m_cnt + 1);
        m_dwell = (ns != m_state) ? 0 : m_dwell + 1;
        m_state = ns;
        e.st = 3'(ns);
        e.pos = PD'(m_pos);
        e.spr = SD'(ns * 4 + (m_dwell / 4) % 4);
        e.act = ns == 3 && m_cnt >= 4 && m_cnt <= 7;
    endtask
    task automatic tick(input logic [3:0] b, input bit h = 1'b0);
        exp_t e;
        repeat (2) begin
            @(negedge sys_clk);
            bus.btn = 4'($urandom);
        end
        @(negedge sys_clk);
        bus.btn = b;
        bus.hit = h;
        bus.frame_tick = 1'b1;
        model_step(b, h, e);
        sb.push_back(e);
        @(posedge sys_clk);
        #1;
        bus.frame_tick = 1'b0;
        bus.hit = 1'b0;
        e = sb.pop_front();
        check("state", int'(bus.state), int'(e.st));
        check("position", int'(bus.position), int'(e.pos));
        check("sprite", int'(bus.sprite), int'(e.spr));
        check("attack_active", int'(bus.attack_active), int'(e.act));
    endtask
    task automatic hit_pulse();
        @(negedge sys_clk);
        bus.hit = 1'b1;
        m_pend = 1'b1;
        @(negedge sys_clk);
        bus.hit = 1'b0;
    endtask
    task automatic reset_pulse();
        @(negedge sys_clk);
        rst = 1'b0;
        #1;
        m_state = 0;
        m_pos = 64;
        m_cnt = 0;
        m_dwell = 0;
        m_pend = 1'b0;
        sb.delete();
        check("rst_state", int'(bus.state), 0);
        check("rst_position", int'(bus.position), 64);
        check("rst_sprite", int'(bus.sprite), 0);
        check("rst_attack_active", int'(bus.attack_active), 0);
        @(negedge sys_clk);
        rst = 1'b1;
    endtask
    initial begin
        int n3, na, n5, mx, p0;
        int seq[9] = '{0, 0, 0, 1, 1, 1, 1, 2, 2};
        bus.btn = 4'd0;
        bus.hit = 1'b0;
        bus.frame_tick = 1'b0;
        reset_pulse();
        repeat (3) tick(4'b0001);
        check("walk_l_state", int'(bus.state), 1);
        check("walk_l_pos", int'(bus.position), 52);
        reset_pulse();
        mx = 0;
        repeat (200) begin
            tick(4'b0010);
            if (int'(bus.position) > mx) mx = int'(bus.position);
        end
        check("walk_r_peak", mx, 576);
        check("walk_r_final", int'(bus.position), 576);
        tick(4'b0000);
        p0 = int'(bus.position);
        n3 = 0;
        na = 0;
        for (int i = 0; i < 13; i++) begin
            tick(i == 0 ? 4'b0100 : (i % 2 ? 4'b0001 : 4'b0010));
            if (bus.state == 3'd3) n3++;
            if (bus.attack_active) na++;
        end
        check("attack_len", n3, 12);
        check("attack_active_len", na, 4);
        check("attack_exit", int'(bus.state), 0);
        check("attack_pos_hold", int'(bus.position), p0);
        tick(4'b1000);
        hit_pulse();
        tick(4'b1000);
        check("block_hit", int'(bus.state), 4);
        tick(4'b0000);
        hit_pulse();
        n5 = 0;
        repeat (17) begin
            tick(4'b0000);
            if (bus.state == 3'd5) n5++;
        end
        check("hitstun_len", n5, 16);
        check("hitstun_exit", int'(bus.state), 0);
        hit_pulse();
        repeat (11) tick(4'b0000);
        hit_pulse();
        n5 = 0;
        repeat (17) begin
            tick(4'b0010);
            if (bus.state == 3'd5) n5++;
        end
        check("rehit_len", n5, 16);
        check("rehit_exit", int'(bus.state), 0);
        tick(4'b0000, 1'b1);
        check("hit_on_tick", int'(bus.state), 5);
        hit_pulse();
        tick(4'b0000, 1'b1);
        repeat (16) tick(4'b0000);
        check("merged_hit_exit", int'(bus.state), 0);
        repeat (2) tick(4'b0010);
        tick(4'b0100);
        repeat (6) tick(4'b0000);
        check("pre_rst_attack", int'(bus.attack_active), 1);
        reset_pulse();
        tick(4'b0000);
        check("post_rst_state", int'(bus.state), 0);
        reset_pulse();
        for (int i = 0; i < 9; i++) begin
            tick(4'b0000);
            check("sprite_seq", int'(bus.sprite), seq[i]);
        end
        tick(4'b0001);
        check("sprite_change", int'(bus.sprite), 4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
